// File: rtl/spram_arbiter_if.sv
// Request/grant/read-return bundle for the two SPRAM requesters plus the SPRAM pins.
// The slave modport is the arbiter; the master modport is the requesters and the RAM macro.
interface spram_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);

  // Port A: CPU data-memory side
  logic              a_req;
  logic              a_we;
  logic [1:0]        a_be;
  logic [ADDR_W-1:0] a_addr;
  logic [15:0]       a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [15:0]       a_rdata;

  // Port B: display/DMA fetch side
  logic              b_req;
  logic              b_we;
  logic [1:0]        b_be;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [15:0]       b_rdata;

  // SB_SPRAM256KA pins
  logic              ram_cs;
  logic              ram_wren;
  logic [3:0]        ram_maskwren;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic [15:0]       ram_dout;

  modport slave (
    input  a_req, a_we, a_be, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_be, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_cs, ram_wren, ram_maskwren, ram_addr, ram_din,
    input  ram_dout
  );

  modport master (
    output a_req, a_we, a_be, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_be, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_cs, ram_wren, ram_maskwren, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/spram_arbiter.sv
// Shares one SB_SPRAM256KA between port A (fixed priority) and port B, with a
// bounded-wait guard that force-grants B and routes the 1-cycle read return.
module spram_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned ADDR_W   = 14
) (
  input  logic           clk,
  input  logic           resetn,
  spram_arbiter_if.slave bus
);

  localparam int unsigned           STARVE_W   = 4;
  localparam logic [STARVE_W-1:0]   STARVE_MAX = STARVE_W'(MAX_WAIT);
  localparam logic [STARVE_W-1:0]   STARVE_ONE = {{(STARVE_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_A    = 2'b01,
    GNT_B    = 2'b10
  } gnt_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_A    = 2'b01,
    OWN_B    = 2'b10
  } owner_e;

  // SPRAM MASKWREN is per nibble; reads must present all ones.
  function automatic logic [3:0] expand_mask(input logic we, input logic [1:0] be);
    logic [3:0] m;
    if (we) begin
      m = {be[1], be[1], be[0], be[0]};
    end else begin
      m = 4'b1111;
    end
    return m;
  endfunction

  logic [STARVE_W-1:0] r_starve;
  owner_e              r_rd_owner;

  gnt_e                w_sel;
  logic                w_force_b;
  logic [STARVE_W-1:0] w_starve_nxt;
  owner_e              w_owner_nxt;
  logic                w_ram_cs;
  logic                w_ram_wren;
  logic [3:0]          w_ram_mask;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [15:0]         w_ram_din;

  // Grant selection: a starved B overrides A's fixed priority for one cycle.
  always_comb begin
    w_sel     = GNT_NONE;
    w_force_b = 1'b0;
    if (!resetn) begin
      w_sel     = GNT_NONE;
      w_force_b = 1'b0;
    end else begin
      w_force_b = bus.b_req && (r_starve == STARVE_MAX);
      if (w_force_b) begin
        w_sel = GNT_B;
      end else if (bus.a_req) begin
        w_sel = GNT_A;
      end else if (bus.b_req) begin
        w_sel = GNT_B;
      end else begin
        w_sel = GNT_NONE;
      end
    end
  end

  // SPRAM drive and read-owner capture for the granted port.
  always_comb begin
    w_ram_cs    = 1'b0;
    w_ram_wren  = 1'b0;
    w_ram_mask  = 4'b0000;
    w_ram_addr  = bus.a_addr;
    w_ram_din   = bus.a_wdata;
    w_owner_nxt = OWN_NONE;
    case (w_sel)
      GNT_A: begin
        w_ram_cs    = 1'b1;
        w_ram_wren  = bus.a_we;
        w_ram_mask  = expand_mask(bus.a_we, bus.a_be);
        w_ram_addr  = bus.a_addr;
        w_ram_din   = bus.a_wdata;
        w_owner_nxt = bus.a_we ? OWN_NONE : OWN_A;
      end
      GNT_B: begin
        w_ram_cs    = 1'b1;
        w_ram_wren  = bus.b_we;
        w_ram_mask  = expand_mask(bus.b_we, bus.b_be);
        w_ram_addr  = bus.b_addr;
        w_ram_din   = bus.b_wdata;
        w_owner_nxt = bus.b_we ? OWN_NONE : OWN_B;
      end
      default: begin
        w_ram_cs    = 1'b0;
        w_ram_wren  = 1'b0;
        w_ram_mask  = 4'b0000;
        w_ram_addr  = bus.a_addr;
        w_ram_din   = bus.a_wdata;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Consecutive-denial count for B; a withdrawn request forgets its history.
  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.b_req || (w_sel == GNT_B)) begin
      w_starve_nxt = {STARVE_W{1'b0}};
    end else if (r_starve < STARVE_MAX) begin
      w_starve_nxt = r_starve + STARVE_ONE;
    end else begin
      w_starve_nxt = r_starve;
    end
  end

  // State registers: starvation counter and owner of the read in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve   <= {STARVE_W{1'b0}};
      r_rd_owner <= OWN_NONE;
    end else begin
      r_starve   <= w_starve_nxt;
      r_rd_owner <= w_owner_nxt;
    end
  end

  assign bus.a_gnt        = (w_sel == GNT_A);
  assign bus.b_gnt        = (w_sel == GNT_B);
  assign bus.ram_cs       = w_ram_cs;
  assign bus.ram_wren     = w_ram_wren;
  assign bus.ram_maskwren = w_ram_mask;
  assign bus.ram_addr     = w_ram_addr;
  assign bus.ram_din      = w_ram_din;

  // SPRAM output is already registered inside the macro, so data passes straight through.
  assign bus.a_rvalid     = (r_rd_owner == OWN_A);
  assign bus.b_rvalid     = (r_rd_owner == OWN_B);
  assign bus.a_rdata      = bus.ram_dout;
  assign bus.b_rdata      = bus.ram_dout;

endmodule

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Shares one SB_SPRAM256KA (16Ki x 16, one-cycle registered read) between two requesters.
- Port A is the CPU data-memory side; port B is the display/DMA fetch side.
- Fixed priority to A, with a starvation guard that forces a grant to B after a bounded wait.
- Handles SPRAM control encoding, byte-mask expansion and read-data return routing.

Parameters:
MAX_WAIT, 4, consecutive cycles B may be denied while requesting before B is force-granted (1..15)
ADDR_W, 14, word address width (SPRAM depth 2^14)

Ports:
clk  in  1  system clock, all logic rising-edge
resetn  in  1  asynchronous active-low reset
a_req  in  1  A requests an access this cycle (level; held until a_gnt)
a_we  in  1  A write (1) / read (0)
a_be  in  2  A byte enables, [1]=bits 15:8, [0]=bits 7:0 (writes only)
a_addr  in  ADDR_W  A word address
a_wdata  in  16  A write data
a_gnt  out  1  combinational; A's access is issued this cycle
a_rvalid  out  1  registered; a_rdata valid (one cycle after a granted read)
a_rdata  out  16  A read data
b_req, b_we, b_be, b_addr, b_wdata  in  1/1/2/ADDR_W/16  as for A
b_gnt, b_rvalid, b_rdata  out  1/1/16  as for A
ram_cs  out  1  SPRAM CHIPSELECT
ram_wren  out  1  SPRAM WREN
ram_maskwren  out  4  SPRAM MASKWREN (nibble enables)
ram_addr  out  ADDR_W  SPRAM ADDRESS
ram_din  out  16  SPRAM DATAIN
ram_dout  in  16  SPRAM DATAOUT

Behaviour:
- Reset (resetn low, async):
  - Registered outputs a_rvalid, b_rvalid clear to 0.
  - starve counter clears to 0.
  - rd_owner clears to NONE.
  - While resetn is low, combinational outputs are forced: a_gnt, b_gnt, ram_cs, ram_wren = 0.
- Arbitration, combinational each cycle, one grant at most:
  - force_b = b_req && (starve == MAX_WAIT).
  - If force_b: grant B.
  - Else if a_req: grant A.
  - Else if b_req: grant B.
  - Else: idle.
- Starve counter, registered:
  - Cleared when b_gnt, or when !b_req.
  - Incremented when b_req && !b_gnt, saturating at MAX_WAIT.
- RAM drive:
  - On a grant: ram_cs = 1, and ram_addr, ram_din, ram_wren come from the granted port.
  - ram_maskwren = {be[1],be[1],be[0],be[0]} on writes, 4'b1111 on reads.
  - Idle: ram_cs = 0, ram_wren = 0, ram_maskwren = 0; ram_addr and ram_din hold port A values (don't-care).
- Read return:
  - rd_owner registers the owner of a granted read (A, B or NONE); writes register NONE.
  - Next cycle: x_rvalid = (rd_owner == x), and x_rdata = ram_dout, passed through combinationally.
  - Read latency is exactly 1 cycle after grant. Write completion is implied by the grant; there is no write response.
- Back-to-back:
  - A port may be granted every cycle.
  - A read granted in cycle N returns in N+1, concurrent with a new grant in N+1.
  - Read data is never lost or misrouted when ownership alternates A,B,A.
- Requester contract:
  - Inputs are held stable while req=1 and gnt=0.
  - Deasserting req before grant withdraws the request, with no side effects.
- Simultaneous events:
  - a_req and b_req together with starve < MAX_WAIT: A is granted and starve increments.
  - At starve == MAX_WAIT, B is granted even though a_req=1; A stalls that single cycle.
- Writes with be == 2'b00: still granted, ram_wren = 1, mask = 0 (no-op write that consumes a slot).
- Reset mid-operation: a pending rd_owner is discarded and no rvalid follows reset release.
- First grant is possible in the first cycle with resetn high.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with a_req=b_req=1 -> all gnt/rvalid/ram_cs = 0. Release -> a_gnt=1 in the first cycle.
2. A writes 0xBEEF to addr 0x0123 with be=2'b11, then reads addr 0x0123 -> ram_maskwren=4'b1111 on the write; a_rvalid=1 with a_rdata=0xBEEF exactly one cycle after the read grant; b_rvalid stays 0.
3. A writes 0x12AA with be=2'b01 over a word holding 0xFFFF -> ram_maskwren=4'b0011; a subsequent read returns 0xFFAA.
4. Starvation, MAX_WAIT=4: a_req and b_req held continuously -> a_gnt for 4 cycles, b_gnt on cycle 5, A on cycles 6-9, B on cycle 10. Grant ratio is exactly 4:1.
5. Interleaved reads: B reads 0x3FFF (=0x5555) and A reads 0x0000 (=0xAAAA) in consecutive cycles -> b_rvalid/b_rdata=0x5555 then a_rvalid/a_rdata=0xAAAA on successive cycles, never swapped.
6. Reset mid-read: assert resetn=0 in the cycle after an A read grant -> a_rvalid stays 0 throughout reset and after release, and starve reads 0.
